// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bundle between the fetch stage and imem.
//   req_valid  fetch -> mem  request valid
//   req_ready  mem -> fetch  request accepted when valid & ready
//   req_addr   fetch -> mem  fetch address
//   resp_valid mem -> fetch  in-order response, no back-pressure
//   resp_data  mem -> fetch  instruction word
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [31:0]     resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch feeding the IF/ID register. Owns the fetch PC, issues in-order
// requests under a credit limit, buffers responses and presents one instruction per cycle.
// Static BTFN prediction (JAL, backward branches) redirects fetch when a taken head pops;
// an EX redirect overrides everything and flushes all fetch state.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             IF/ID not accepting; head is held
//   redirect_valid/pc EX redirect request and target
//   imem              request/response bundle (master side)
//   pc_out, pc_p4_out head PC and head PC + 4
//   instr_out         head instruction (NOP when invalid)
//   branch_take_out   head predicted taken
//   instr_valid_out   head valid
module fetch_stage #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_p4_out,
    output logic [31:0]     instr_out,
    output logic            branch_take_out,
    output logic            instr_valid_out
);
    localparam int unsigned CW        = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam int unsigned PW        = $clog2(MAX_OUTSTANDING);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    logic [XLEN-1:0] fetch_pc_q;
    logic [CW-1:0]   outstanding_q, drop_cnt_q, buf_cnt_q;

    // PCs of requests in flight, popped as responses return (dropped or not).
    logic [XLEN-1:0] ifq_pc_q [MAX_OUTSTANDING];
    logic [PW-1:0]   ifq_wr_q, ifq_rd_q;

    // Response buffer; prediction is resolved at write time.
    logic [XLEN-1:0] buf_pc_q     [MAX_OUTSTANDING];
    logic [31:0]     buf_instr_q  [MAX_OUTSTANDING];
    logic            buf_take_q   [MAX_OUTSTANDING];
    logic [XLEN-1:0] buf_target_q [MAX_OUTSTANDING];
    logic [PW-1:0]   buf_hd_q, buf_tl_q;

    logic            head_valid, pop, pred_flush, flush, accept, resp_keep;
    logic [CW-1:0]   credit_used, outstanding_d, buf_cnt_d;
    logic [31:0]     d;
    logic [6:0]      op;
    logic [XLEN-1:0] imm_j, imm_b, resp_pc, resp_target;
    logic            resp_take;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head_valid = (buf_cnt_q != '0) && !rst;
        pop        = head_valid && !stall && !redirect_valid;
        pred_flush = pop && buf_take_q[buf_hd_q];
        flush      = redirect_valid || pred_flush;

        // Credits count both in-flight requests and buffered responses, so the buffer never
        // overflows; the popping head frees its slot in the same cycle.
        credit_used    = outstanding_q + buf_cnt_q - CW'(pop);
        imem.req_valid = !rst && !flush && (credit_used < CW'(MAX_OUTSTANDING));
        imem.req_addr  = fetch_pc_q;
        accept         = imem.req_valid && imem.req_ready;

        resp_keep     = imem.resp_valid && (drop_cnt_q == '0) && !flush;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem.resp_valid);
        buf_cnt_d     = buf_cnt_q + CW'(resp_keep) - CW'(pop);

        d           = imem.resp_data;
        op          = d[6:0];
        imm_j       = {{(XLEN-20){d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
        imm_b       = {{(XLEN-12){d[31]}}, d[7], d[30:25], d[11:8], 1'b0};
        resp_pc     = ifq_pc_q[ifq_rd_q];
        resp_take   = (op == OP_JAL) || ((op == OP_BRANCH) && d[31]);
        resp_target = resp_pc + ((op == OP_JAL) ? imm_j : imm_b);

        instr_valid_out = head_valid;
        pc_out          = head_valid ? buf_pc_q[buf_hd_q] : '0;
        pc_p4_out       = head_valid ? buf_pc_q[buf_hd_q] + XLEN'(4) : '0;
        instr_out       = head_valid ? buf_instr_q[buf_hd_q] : NOP;
        branch_take_out = head_valid && buf_take_q[buf_hd_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            buf_cnt_q     <= '0;
            ifq_wr_q      <= '0;
            ifq_rd_q      <= '0;
            buf_hd_q      <= '0;
            buf_tl_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;

            if (accept) begin
                ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
                ifq_wr_q           <= ptr_inc(ifq_wr_q);
            end
            if (imem.resp_valid) begin
                ifq_rd_q <= ptr_inc(ifq_rd_q);
            end

            // A flush never coincides with an accept, so these are exclusive.
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc;
            end else if (pred_flush) begin
                fetch_pc_q <= buf_target_q[buf_hd_q];
            end else if (accept) begin
                fetch_pc_q <= fetch_pc_q + XLEN'(4);
            end

            // Everything still in flight after a flush belongs to the abandoned path.
            if (flush) begin
                drop_cnt_q <= outstanding_d;
            end else if (imem.resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_q <= drop_cnt_q - CW'(1);
            end

            if (flush) begin
                buf_cnt_q <= '0;
                buf_hd_q  <= '0;
                buf_tl_q  <= '0;
            end else begin
                if (resp_keep) begin
                    buf_pc_q[buf_tl_q]     <= resp_pc;
                    buf_instr_q[buf_tl_q]  <= d;
                    buf_take_q[buf_tl_q]   <= resp_take;
                    buf_target_q[buf_tl_q] <= resp_target;
                    buf_tl_q               <= ptr_inc(buf_tl_q);
                end
                if (pop) begin
                    buf_hd_q <= ptr_inc(buf_hd_q);
                end
                buf_cnt_q <= buf_cnt_d;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ = 32'hFE00_0CE3;  // beq x0,x0,-8
    localparam logic [31:0] JAL = 32'h0400_006F;  // jal x0,+64

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc, pc_out, pc_p4_out, instr_out;
    logic        branch_take_out, instr_valid_out;

    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .MAX_OUTSTANDING(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem            (imem),
        .pc_out          (pc_out),
        .pc_p4_out       (pc_p4_out),
        .instr_out       (instr_out),
        .branch_take_out (branch_take_out),
        .instr_valid_out (instr_valid_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int cyc        = 0;
    int lat        = 1;
    bit rand_mode  = 0;
    bit rand_ready = 0;

    function automatic logic [31:0] enc_jal(input int off);
        logic [20:0] i;
        i = off[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input int off, input logic [2:0] f3);
        logic [12:0] i;
        i = off[12:0];
        return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
    endfunction

    // Program image plus the prediction the fetch stage ought to make for each word.
    function automatic void gen(input logic [31:0] a, output logic [31:0] ins,
                                output bit take, output logic [31:0] off);
        logic [31:0] h;
        int o;
        take = 0;
        off  = 32'd4;
        if (!rand_mode) begin
            case (a)
                32'h20:  begin ins = BEQ; take = 1; off = 32'hFFFF_FFF8; end
                32'h24:  ins = 32'h0010_0093;
                32'h300: begin ins = JAL; take = 1; off = 32'h40; end
                default: ins = NOP;
            endcase
        end else begin
            h = a * 32'h9E37_79B1;
            h = h ^ (h >> 15);
            case (h[3:0])
                4'd0: begin o = (int'(h[9:4]) - 32) * 4; ins = enc_jal(o); take = 1; off = o; end
                4'd1: begin o = -4 * (1 + int'(h[6:4])); ins = enc_br(o, h[14:12]); take = 1;
                            off = o; end
                4'd2: begin o = 4 * (1 + int'(h[6:4])); ins = enc_br(o, h[14:12]); end
                4'd3: ins = {h[31:12], 5'd3, 7'b0110111};
                default: ins = {h[31:20], 5'd0, 3'b000, h[11:7], 7'b0010011};
            endcase
        end
    endfunction

    task automatic drive(input bit r, input bit s, input bit rv, input logic [31:0] rpc);
        logic [31:0] ins, off;
        bit tk;
        @(negedge clk);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem.req_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        imem.resp_valid = 1'b0;
        imem.resp_data  = $urandom;
        if (r) begin
            mq.delete();
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            gen(mq[0].addr, ins, tk, off);
            imem.resp_valid = 1'b1;
            imem.resp_data  = ins;
            void'(mq.pop_front());
        end
        #1;
    endtask

    task automatic close_cycle();
        int due;
        mreq_t m;
        if (imem.req_valid && imem.req_ready) begin
            if (rand_mode) lat = $urandom_range(1, 3);
            due = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
            m.addr = imem.req_addr;
            m.due  = due;
            mq.push_back(m);
            if (rand_mode) chk("inflight_le_max", 32'(mq.size() <= 2), 1);
        end
        @(posedge clk);
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          stall;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        bit          exp_take;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input bit r, input bit s, input bit er, input logic [31:0] ea,
                           input bit ev, input logic [31:0] ep, input logic [31:0] ei,
                           input bit et);
        vec_t v;
        v.rst = r; v.stall = s; v.exp_req = er; v.exp_addr = ea;
        v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei; v.exp_take = et;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_pc, ins, off, rpc;
        bit tk, r, s, rv, found, first_req, first_valid, seen;
        int pops;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem.req_ready = 1'b1; imem.resp_valid = 1'b0; imem.resp_data = '0;

        // Reset, sequential NOP stream, backward-taken beq at 0x20 looping to 0x18.
        add_vec(1, 0, 0, 0, 0, 0, NOP, 0);
        add_vec(1, 0, 0, 0, 0, 0, NOP, 0);
        for (int k = 2; k <= 11; k++)
            add_vec(0, 0, 1, 32'(4 * (k - 2)), k >= 4, (k >= 4) ? 32'(4 * (k - 4)) : 32'h0, NOP, 0);
        add_vec(0, 0, 0, 0,     1, 32'h20, BEQ, 1);
        add_vec(0, 0, 1, 32'h18, 0, 0,      NOP, 0);
        add_vec(0, 0, 1, 32'h1c, 0, 0,      NOP, 0);
        add_vec(0, 0, 1, 32'h20, 1, 32'h18, NOP, 0);
        add_vec(0, 0, 1, 32'h24, 1, 32'h1c, NOP, 0);
        add_vec(0, 0, 0, 0,     1, 32'h20, BEQ, 1);
        // Stall held six cycles with the head at 0x4: credits exhausted, head stable.
        add_vec(1, 0, 0, 0, 0, 0, NOP, 0);
        add_vec(0, 0, 1, 32'h0, 0, 0, NOP, 0);
        add_vec(0, 0, 1, 32'h4, 0, 0, NOP, 0);
        add_vec(0, 0, 1, 32'h8, 1, 32'h0, NOP, 0);
        for (int k = 0; k < 6; k++) add_vec(0, 1, 0, 0, 1, 32'h4, NOP, 0);
        add_vec(0, 0, 1, 32'hc,  1, 32'h4, NOP, 0);
        add_vec(0, 0, 1, 32'h10, 1, 32'h8, NOP, 0);
        add_vec(0, 0, 1, 32'h14, 1, 32'hc, NOP, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, 0, 0);
            chk($sformatf("v%0d_req_valid", i), 32'(imem.req_valid), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                chk($sformatf("v%0d_req_addr", i), imem.req_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid_out), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_pc", i), pc_out, vecs[i].exp_pc);
            chk($sformatf("v%0d_pc_p4", i), pc_p4_out,
                vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'h0);
            chk($sformatf("v%0d_instr", i), instr_out, vecs[i].exp_instr);
            chk($sformatf("v%0d_take", i), 32'(branch_take_out), 32'(vecs[i].exp_take));
            close_cycle();
        end

        // External redirect to 0x100 with responses still in flight (3-cycle memory).
        lat = 3;
        drive(1, 0, 0, 0); close_cycle();
        drive(0, 0, 0, 0); close_cycle();
        drive(0, 0, 0, 0); close_cycle();
        drive(0, 0, 1, 32'h100);
        chk("t4_no_req_on_redirect", 32'(imem.req_valid), 0);
        close_cycle();
        first_req = 1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(0, 0, 0, 0);
            if (imem.req_valid && first_req) begin
                chk("t4_first_req_addr", imem.req_addr, 32'h100);
                first_req = 0;
            end
            if (instr_valid_out) begin
                chk("t4_first_valid_pc", pc_out, 32'h100);
                found = 1;
            end
            close_cycle();
        end
        chk("t4_valid_seen", 32'(found), 1);

        // JAL head pops in the same cycle as an external redirect to 0x200.
        lat = 1;
        drive(1, 0, 0, 0); close_cycle();
        drive(0, 0, 1, 32'h300); close_cycle();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(0, 0, 0, 0);
            if (instr_valid_out && pc_out == 32'h300) begin
                chk("t6_jal_take", 32'(branch_take_out), 1);
                redirect_valid = 1'b1;
                redirect_pc    = 32'h200;
                #1;
                chk("t6_no_req_on_redirect", 32'(imem.req_valid), 0);
                found = 1;
            end
            close_cycle();
        end
        chk("t6_jal_reached", 32'(found), 1);
        first_req = 1; first_valid = 1; seen = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0);
            if (imem.req_valid && imem.req_ready) begin
                if (first_req) chk("t6_first_req_addr", imem.req_addr, 32'h200);
                first_req = 0;
                if (imem.req_addr == 32'h340) seen = 1;
            end
            if (instr_valid_out) begin
                if (first_valid) chk("t6_first_valid_pc", pc_out, 32'h200);
                first_valid = 0;
                if (pc_out == 32'h340) seen = 1;
            end
            close_cycle();
        end
        chk("t6_jal_target_unfetched", 32'(seen), 0);
        chk("t6_valid_seen", 32'(!first_valid), 1);

        // Random run against a program-order model: each popped head must be the next
        // instruction along the predicted path, restarted by redirects and resets.
        rand_mode = 1; rand_ready = 1;
        drive(1, 0, 0, 0); close_cycle();
        exp_pc = 32'h0; pops = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            rv  = !r && ($urandom_range(0, 29) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rpc = 32'($urandom_range(0, 1023)) << 2;
            drive(r, s, rv, rpc);
            if (r) begin
                chk("rand_rst_valid", 32'(instr_valid_out), 0);
                chk("rand_rst_req", 32'(imem.req_valid), 0);
                exp_pc = 32'h0;
            end else begin
                if (!instr_valid_out) begin
                    chk("rand_idle_instr", instr_out, NOP);
                end else if (!s && !rv) begin
                    gen(exp_pc, ins, tk, off);
                    chk("rand_pc", pc_out, exp_pc);
                    chk("rand_pc_p4", pc_p4_out, exp_pc + 32'd4);
                    chk("rand_instr", instr_out, ins);
                    chk("rand_take", 32'(branch_take_out), 32'(tk));
                    exp_pc = tk ? exp_pc + off : exp_pc + 32'd4;
                    pops++;
                end
                if (rv) exp_pc = rpc;
            end
            close_cycle();
        end
        chk("rand_progress", 32'(pops >= 200), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
